mem_loader: RTL and testbench
=============================

Name: mem_loader

Overview:
- Boot/program loader upstream of the data memory.
- Consumes a byte stream from the UART receiver, assembles little-endian 32-bit words, and issues word-aligned writes on the data-memory write port (wr/addr/wdata).
- Holds the CPU off the memory port while loading.
- Sits between the UART RX and the CPU/loader mux in front of data memory.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word aligned
MAX_WORDS, 64, largest accepted frame length in words (the data memory decodes 256 bytes)
TIMEOUT, 100000, max idle clk cycles between bytes inside a frame before abort
TW, 17, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
arm  in  1  one-cycle pulse; enables reception of one frame
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
mem_wr  out  1  write strobe to data memory, one cycle per word
mem_addr  out  32  word-aligned byte address
mem_wdata  out  32  assembled word
cpu_hold  out  1  high while loader owns the memory port
busy  out  1  frame in progress
done  out  1  one-cycle pulse, frame completed successfully
err  out  1  one-cycle pulse, frame rejected or aborted
words_loaded  out  16  words written in current/last frame

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0; mem_addr=BASE_ADDR; byte index, length, and timeout counters cleared. Takes effect mid-frame immediately. mem_wr drops asynchronously. Words already written stay in memory.
- Frame format: len_lo, len_hi (N, 16-bit LE), then 4*N data bytes. Each word is LE: first byte is wdata[7:0].
- States and transitions:
  - IDLE: rx_valid ignored. arm=1 -> ARMED. cpu_hold=1 from ARMED onward.
  - ARMED: waits indefinitely; no timeout. rx_valid -> latch len_lo -> LEN_HI.
  - LEN_HI: rx_valid -> latch len_hi, then:
    - N=0 -> DONE.
    - N>MAX_WORDS -> ERR.
    - else -> DATA; byte index=0, words_loaded=0.
  - DATA: each rx_valid shifts a byte into lane [index]; index wraps 3->0. On the 4th byte, next cycle: mem_wr=1, mem_wdata=assembled word, mem_addr=BASE_ADDR+4*words_loaded (pre-increment). words_loaded increments in that same cycle. After the N-th write -> DONE.
  - DONE: done=1 for one cycle, cpu_hold released in that same cycle -> IDLE.
  - ERR: err=1 for one cycle, cpu_hold released -> IDLE.
- Latency: 4th byte strobe at cycle t -> mem_wr at t+1 -> done at t+2 for the last word.
- busy=1 in LEN_HI and DATA.
- Timeout: counter clears on every rx_valid and counts in LEN_HI/DATA. Reaching TIMEOUT -> ERR. Partial writes are not undone.
- Simultaneous events:
  - rx_valid in the same cycle as a timeout hit: the byte wins and the counter clears.
  - arm while not IDLE is ignored.
  - rx_valid in DONE/ERR is dropped.
- Back-to-back rx_valid (every cycle) must be supported without loss. The write register is separate from the assembly shift register.
- mem_addr wraps modulo 2^32 (unreachable with legal MAX_WORDS).

Decomposition:
- Shared package: state encoding (IDLE, ARMED, LEN_HI, DATA, DONE, ERR) and the frame length-field width (16).
- One natural sub-module, ld_timeout_cnt: TW-bit counter with clear/enable, flagging hit at TIMEOUT.
- Byte assembly and FSM remain in mem_loader.

Test Plan:
- Reset then arm, bytes 02 00 78 56 34 12 EF BE AD DE -> two mem_wr pulses:
  - addr 0x0, data 0x12345678
  - addr 0x4, data 0xDEADBEEF
  - done pulse one cycle after the 2nd write; words_loaded=2; cpu_hold low after done.
- arm, bytes 41 00 -> err pulse, no mem_wr, back to IDLE (65 > MAX_WORDS).
- arm, bytes 00 00 -> done pulse, no mem_wr, words_loaded=0.
- Bytes streamed with rx_valid every cycle, N=3 -> 3 writes at 0x0/0x4/0x8, each exactly one cycle after its 4th byte; no byte lost.
- arm, 01 00 AA BB, then silence of TIMEOUT cycles (TIMEOUT overridden to 50) -> err pulse, no mem_wr, IDLE.
- Assert reset mid-DATA after a single 0x11 byte -> all outputs 0 immediately. A later rx_valid without arm produces no writes.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// Shared types and widths for the boot/program loader.
package mem_loader_pkg;

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_LEN_HI,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/mem_loader_if.sv
// Data-memory write port driven by the loader.
interface mem_loader_if;
    import mem_loader_pkg::*;

    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (output mem_wr, output mem_addr, output mem_wdata);
    modport slave  (input  mem_wr, input  mem_addr, input  mem_wdata);

endinterface

// File: rtl/mem_loader_timeout.sv
// Inter-byte idle counter; hit_c flags the TIMEOUT-th idle cycle.
module ld_timeout_cnt #(
    parameter int unsigned TW      = 17,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit_c
);

    logic [TW-1:0] cnt;

    // A byte in the hit cycle wins, so clr masks the hit.
    assign hit_c = en && !clr && (cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (!hit_c) begin
            cnt <= cnt + TW'(1);
        end
    end

endmodule

// File: rtl/mem_loader.sv
// UART byte stream -> little-endian word writes into data memory, framed by a 16-bit word count.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 64,
    parameter int unsigned TIMEOUT   = 100000,
    parameter int unsigned TW        = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    mem_loader_if.master     mem,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_loaded
);

    state_t           state;
    state_t           next_state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_rx_c;
    logic [1:0]       idx;
    logic [23:0]      asm_q;
    logic             to_en_c;
    logic             to_hit_c;

    assign len_rx_c = {rx_data, len[7:0]};
    assign to_en_c  = (state == ST_LEN_HI) || (state == ST_DATA);

    ld_timeout_cnt #(
        .TW      (TW),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst_n (reset),
        .clr   (rx_valid),
        .en    (to_en_c),
        .hit_c (to_hit_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (arm) next_state = ST_ARMED;
            ST_ARMED:  if (rx_valid) next_state = ST_LEN_HI;
            ST_LEN_HI: begin
                if (rx_valid) begin
                    if (len_rx_c == '0)                       next_state = ST_DONE;
                    else if (len_rx_c > LEN_W'(MAX_WORDS))    next_state = ST_ERR;
                    else                                      next_state = ST_DATA;
                end else if (to_hit_c) begin
                    next_state = ST_ERR;
                end
            end
            // words_loaded already counts the word on the bus while mem_wr is high
            ST_DATA: begin
                if (mem.mem_wr && (words_loaded == len)) next_state = ST_DONE;
                else if (to_hit_c)                       next_state = ST_ERR;
            end
            ST_DONE:   next_state = ST_IDLE;
            ST_ERR:    next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len           <= '0;
            idx           <= '0;
            asm_q         <= '0;
            words_loaded  <= '0;
            mem.mem_wr    <= 1'b0;
            mem.mem_addr  <= BASE_ADDR;
            mem.mem_wdata <= '0;
            cpu_hold      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            mem.mem_wr <= 1'b0;
            cpu_hold   <= (next_state == ST_ARMED) || (next_state == ST_LEN_HI)
                       || (next_state == ST_DATA);
            busy       <= (next_state == ST_LEN_HI) || (next_state == ST_DATA);
            done       <= (next_state == ST_DONE);
            err        <= (next_state == ST_ERR);

            if (rx_valid && (state == ST_ARMED)) begin
                len[7:0] <= rx_data;
            end

            if (rx_valid && (state == ST_LEN_HI)) begin
                len[15:8]    <= rx_data;
                idx          <= '0;
                words_loaded <= '0;
            end

            // Bytes 0..2 shift in from the top; the 4th completes the word into the write register.
            if (rx_valid && (state == ST_DATA)) begin
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    mem.mem_wr    <= 1'b1;
                    mem.mem_wdata <= {rx_data, asm_q};
                    mem.mem_addr  <= BASE_ADDR + 32'({words_loaded, 2'b00});
                    words_loaded  <= words_loaded + LEN_W'(1);
                end else begin
                    asm_q <= {rx_data, asm_q[23:8]};
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed frames plus randomized frames against a frame-level model.
module tb_mem_loader;
    import mem_loader_pkg::*;

    localparam int unsigned TO   = 50;
    localparam int unsigned MAXW = 64;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        arm = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        cpu_hold, busy, done, err;
    logic [15:0] words_loaded;

    mem_loader_if mem ();

    mem_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW),
        .TIMEOUT   (TO),
        .TW        (17)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .mem          (mem),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t wr_q[$];
    int  byte_cyc[$];
    int  done_cyc[$];
    int  err_cyc[$];

    // Event log sampled mid-cycle
    always @(negedge clk) begin
        if (rx_valid)   byte_cyc.push_back(cyc);
        if (mem.mem_wr) wr_q.push_back('{cyc, mem.mem_addr, mem.mem_wdata});
        if (done)       done_cyc.push_back(cyc);
        if (err)        err_cyc.push_back(cyc);
    end

    // Frame-level reference: expected writes derived from the frame bytes
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_n;
    bit          exp_ok;

    function automatic void build_model(input logic [7:0] f[$]);
        exp_addr.delete();
        exp_data.delete();
        exp_n  = int'(f[0]) + 256 * int'(f[1]);
        exp_ok = (exp_n <= int'(MAXW));
        if (exp_ok) begin
            for (int i = 0; i < exp_n; i++) begin
                exp_addr.push_back(BASE + 32'(4 * i));
                exp_data.push_back({f[5 + 4*i], f[4 + 4*i], f[3 + 4*i], f[2 + 4*i]});
            end
        end
    endfunction

    task automatic make_frame(input int n, output logic [7:0] f[$]);
        f.delete();
        f.push_back(8'(n));
        f.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) f.push_back(8'($urandom));
    endtask

    task automatic clear_log();
        wr_q.delete();
        byte_cyc.delete();
        done_cyc.delete();
        err_cyc.delete();
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
    endtask

    task automatic send(input logic [7:0] f[$], input int gap_max);
        for (int i = 0; i < f.size(); i++) begin
            rx_valid = 1'b1;
            rx_data  = f[i];
            @(posedge clk); #1;
            rx_valid = 1'b0;
            repeat ($urandom_range(gap_max, 0)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_end(input int budget);
        int k = 0;
        while (done_cyc.size() == 0 && err_cyc.size() == 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({mem.mem_wr, cpu_hold, busy, done, err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b want 00000", {mem.mem_wr, cpu_hold, busy, done, err});
        end
        tests++;
        if (words_loaded !== 16'd0) begin
            fails++;
            $display("FAIL reset_words: got %0d want 0", words_loaded);
        end
        tests++;
        if (mem.mem_addr !== BASE) begin
            fails++;
            $display("FAIL reset_addr: got %h want %h", mem.mem_addr, BASE);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_two_words();
        logic [7:0] f[$];
        f = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        clear_log();
        pulse_arm();
        tests++;
        if ({cpu_hold, busy} !== 2'b10) begin
            fails++;
            $display("FAIL armed_hold: got hold/busy %b want 10", {cpu_hold, busy});
        end
        send(f, 2);
        wait_end(100);
        tests++;
        if (wr_q.size() != 2) begin
            fails++;
            $display("FAIL two_wr_count: got %0d want 2", wr_q.size());
        end else begin
            tests++;
            if (wr_q[0].addr !== 32'h0 || wr_q[0].data !== 32'h1234_5678 || wr_q[0].c != byte_cyc[5] + 1) begin
                fails++;
                $display("FAIL two_wr0: got %h/%h @%0d want 00000000/12345678 @%0d",
                         wr_q[0].addr, wr_q[0].data, wr_q[0].c, byte_cyc[5] + 1);
            end
            tests++;
            if (wr_q[1].addr !== 32'h4 || wr_q[1].data !== 32'hDEAD_BEEF || wr_q[1].c != byte_cyc[9] + 1) begin
                fails++;
                $display("FAIL two_wr1: got %h/%h @%0d want 00000004/deadbeef @%0d",
                         wr_q[1].addr, wr_q[1].data, wr_q[1].c, byte_cyc[9] + 1);
            end
        end
        tests++;
        if (done_cyc.size() != 1 || err_cyc.size() != 0 || done_cyc[0] != byte_cyc[9] + 2) begin
            fails++;
            $display("FAIL two_done: got done=%0d err=%0d want one done at cycle %0d",
                     done_cyc.size(), err_cyc.size(), byte_cyc[9] + 2);
        end
        tests++;
        if (words_loaded !== 16'd2 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL two_final: got words=%0d hold=%b busy=%b want 2/0/0", words_loaded, cpu_hold, busy);
        end
    endtask

    task automatic test_too_long();
        logic [7:0] f[$];
        f = '{8'h41, 8'h00};
        clear_log();
        pulse_arm();
        send(f, 1);
        wait_end(20);
        tests++;
        if (err_cyc.size() != 1 || done_cyc.size() != 0 || wr_q.size() != 0 || err_cyc[0] != byte_cyc[1] + 1) begin
            fails++;
            $display("FAIL too_long: got err=%0d done=%0d wr=%0d want err=1 done=0 wr=0",
                     err_cyc.size(), done_cyc.size(), wr_q.size());
        end
        tests++;
        if (cpu_hold !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL too_long_idle: got hold=%b busy=%b want 0/0", cpu_hold, busy);
        end
    endtask

    task automatic test_zero_len();
        logic [7:0] f[$];
        f = '{8'h00, 8'h00};
        clear_log();
        pulse_arm();
        send(f, 0);
        wait_end(20);
        tests++;
        if (done_cyc.size() != 1 || err_cyc.size() != 0 || wr_q.size() != 0 || done_cyc[0] != byte_cyc[1] + 1) begin
            fails++;
            $display("FAIL zero_len: got done=%0d err=%0d wr=%0d want done=1 err=0 wr=0",
                     done_cyc.size(), err_cyc.size(), wr_q.size());
        end
        tests++;
        if (words_loaded !== 16'd0 || cpu_hold !== 1'b0) begin
            fails++;
            $display("FAIL zero_len_final: got words=%0d hold=%b want 0/0", words_loaded, cpu_hold);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] f[$];
        make_frame(3, f);
        build_model(f);
        clear_log();
        pulse_arm();
        send(f, 0);
        wait_end(40);
        tests++;
        if (wr_q.size() != exp_addr.size()) begin
            fails++;
            $display("FAIL b2b_count: got %0d want %0d", wr_q.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                tests++;
                if (wr_q[i].addr !== exp_addr[i] || wr_q[i].data !== exp_data[i] || wr_q[i].c != byte_cyc[5 + 4*i] + 1) begin
                    fails++;
                    $display("FAIL b2b_wr%0d: got %h/%h @%0d want %h/%h @%0d", i, wr_q[i].addr, wr_q[i].data,
                             wr_q[i].c, exp_addr[i], exp_data[i], byte_cyc[5 + 4*i] + 1);
                end
            end
        end
        tests++;
        if (done_cyc.size() != 1 || words_loaded !== 16'(exp_n)) begin
            fails++;
            $display("FAIL b2b_done: got done=%0d words=%0d want 1/%0d", done_cyc.size(), words_loaded, exp_n);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] f[$];
        int         n;
        int         end_c;
        for (int r = 0; r < 6; r++) begin
            n = (r == 0) ? int'(MAXW) : int'($urandom_range(12, 1));
            make_frame(n, f);
            build_model(f);
            clear_log();
            pulse_arm();
            send(f, (r == 0) ? 0 : 3);
            wait_end(200);
            tests++;
            if (wr_q.size() != exp_addr.size()) begin
                fails++;
                $display("FAIL rand%0d_count: got %0d want %0d", r, wr_q.size(), exp_addr.size());
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    tests++;
                    if (wr_q[i].addr !== exp_addr[i] || wr_q[i].data !== exp_data[i] || wr_q[i].c != byte_cyc[5 + 4*i] + 1) begin
                        fails++;
                        $display("FAIL rand%0d_wr%0d: got %h/%h @%0d want %h/%h", r, i, wr_q[i].addr,
                                 wr_q[i].data, wr_q[i].c, exp_addr[i], exp_data[i]);
                    end
                end
            end
            end_c = (byte_cyc.size() == 2 + 4 * exp_n) ? byte_cyc[1 + 4 * exp_n] + 2 : -1;
            tests++;
            if (done_cyc.size() != 1 || err_cyc.size() != 0 || done_cyc[0] != end_c || words_loaded !== 16'(exp_n)) begin
                fails++;
                $display("FAIL rand%0d_done: got done=%0d err=%0d words=%0d want done@%0d words=%0d",
                         r, done_cyc.size(), err_cyc.size(), words_loaded, end_c, exp_n);
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] f[$];
        int         last;
        f = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        clear_log();
        pulse_arm();
        send(f, 0);
        last = byte_cyc[3];
        wait_end(int'(TO) + 20);
        tests++;
        if (err_cyc.size() != 1 || done_cyc.size() != 0 || wr_q.size() != 0) begin
            fails++;
            $display("FAIL timeout_err: got err=%0d done=%0d wr=%0d want 1/0/0", err_cyc.size(), done_cyc.size(), wr_q.size());
        end else begin
            tests++;
            if (err_cyc[0] < last + int'(TO) || err_cyc[0] > last + int'(TO) + 2) begin
                fails++;
                $display("FAIL timeout_when: got err at %0d want %0d..%0d", err_cyc[0], last + int'(TO), last + int'(TO) + 2);
            end
        end
        tests++;
        if (cpu_hold !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_idle: got hold=%b busy=%b want 0/0", cpu_hold, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] f[$];
        f = '{8'h01, 8'h00, 8'h11};
        clear_log();
        pulse_arm();
        send(f, 0);
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({mem.mem_wr, cpu_hold, busy, done, err} !== 5'b0 || words_loaded !== 16'd0 || mem.mem_addr !== BASE) begin
            fails++;
            $display("FAIL reset_mid: got flags=%b words=%0d addr=%h want 0/0/%h",
                     {mem.mem_wr, cpu_hold, busy, done, err}, words_loaded, mem.mem_addr, BASE);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        f = '{8'h01, 8'h00, 8'h22, 8'h33, 8'h44, 8'h55};
        clear_log();
        send(f, 0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        tests++;
        if (wr_q.size() != 0 || cpu_hold !== 1'b0 || done_cyc.size() != 0) begin
            fails++;
            $display("FAIL no_arm: got wr=%0d hold=%b done=%0d want 0/0/0", wr_q.size(), cpu_hold, done_cyc.size());
        end
        // Reset landing on a live write strobe
        f = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        pulse_arm();
        send(f, 0);
        tests++;
        if (mem.mem_wr !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_wr: got mem_wr=%b want 1", mem.mem_wr);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (mem.mem_wr !== 1'b0 || cpu_hold !== 1'b0 || words_loaded !== 16'd0) begin
            fails++;
            $display("FAIL async_drop: got mem_wr=%b hold=%b words=%0d want 0/0/0", mem.mem_wr, cpu_hold, words_loaded);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_two_words();
        test_too_long();
        test_zero_len();
        test_back_to_back();
        test_random_frames();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", tests);
        $fatal(1);
    end

endmodule
